button_conditioner: RTL and testbench

- Upstream front end for the lab processor's LoadA/LoadB/Execute push-buttons.
- Per channel: 2-flop synchronizer, then debounce FSM with stable-sample counter.
- Emits a clean debounced level plus one-cycle press and release strobes.
- Processor control consumes the level outputs. Strobes serve later load-on-edge logic.

---
 rtl/btn_pkg.sv | 30 +++
 rtl/btn_debounce_ch.sv | 136 +++++++++++++
 rtl/button_conditioner.sv | 45 ++++
 tb/tb_button_conditioner.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared types and constants for the push-button front end.
//   btn_state_t    : per-channel debounce FSM state
//   BTN_*          : channel index of each lab button within RawIn/Level/...
//   SYNC_RESET_VAL : reset value of the synchronizer flops (inactive raw level)
// Configuration macro: BTN_ACTIVE_LOW_EN (raw buttons are active-low when set).
// ----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      STABLE_LO,
      WAIT_HI,
      STABLE_HI,
      WAIT_LO
   } btn_state_t;

   localparam int BTN_LOADA = 0;
   localparam int BTN_LOADB = 1;
   localparam int BTN_EXEC  = 2;

   // The synchronizer resets to the level an idle board button presents, so
   // leaving reset never looks like a press.
`ifdef BTN_ACTIVE_LOW_EN
   localparam logic SYNC_RESET_VAL = 1'b1;
`else
   localparam logic SYNC_RESET_VAL = 1'b0;
`endif

endpackage

// File: rtl/btn_debounce_ch.sv
// ----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchronizer, debounce FSM with a stable-sample
// counter, registered level and one-cycle press/release strobes.
// Ports:
//   clk           in  system clock, rising edge
//   rst           in  asynchronous active-high reset
//   raw           in  unsynchronized button input
//   level         out debounced level (1 in STABLE_HI / WAIT_LO)
//   press         out one-cycle strobe coincident with level rising
//   release_pulse out one-cycle strobe coincident with level falling
// Configuration macro: BTN_ACTIVE_LOW_EN inverts the synchronized sample.
// ----------------------------------------------------------------------------
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic             s;
   btn_state_t       state;
   btn_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             level_nxt;
   logic             press_nxt;
   logic             release_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would collapse the 2-flop synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= SYNC_RESET_VAL;
         sync2 <= SYNC_RESET_VAL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

`ifdef BTN_ACTIVE_LOW_EN
   assign s = ~sync2;
`else
   assign s = sync2;
`endif

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         STABLE_LO: begin
            if (s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = STABLE_HI;
               end else begin
                  state_nxt = WAIT_HI;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         WAIT_HI: begin
            if (!s) begin
               // Glitch: drop back silently and restart qualification.
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = STABLE_LO;
               end else begin
                  state_nxt = WAIT_LO;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase

      // Outputs are registered from the next state so level and strobes change
      // on the same edge that completes qualification.
      level_nxt   = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
      press_nxt   = (state_nxt == STABLE_HI) &&
                    ((state == STABLE_LO) || (state == WAIT_HI));
      release_nxt = (state_nxt == STABLE_LO) &&
                    ((state == STABLE_HI) || (state == WAIT_LO));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= STABLE_LO;
         cnt           <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         level         <= level_nxt;
         press         <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Front end for the lab processor push-buttons (bit 0 LoadA, bit 1 LoadB,
// bit 2 Execute). Each channel is synchronized and debounced independently.
// Ports:
//   Clk     in  system clock, rising edge
//   Reset   in  asynchronous active-high reset
//   RawIn   in  [N_BTN] unsynchronized button inputs
//   Level   out [N_BTN] debounced, synchronized button state
//   Press   out [N_BTN] one-cycle strobe on Level rising
//   Release out [N_BTN] one-cycle strobe on Level falling
// Parameters: N_BTN channels; DEBOUNCE_CYCLES agreeing samples to change level
// (must be >= 1; the board top raises it well above the simulation default).
// Configuration macro: BTN_ACTIVE_LOW_EN treats RawIn as active-low.
// ----------------------------------------------------------------------------
module button_conditioner #(
   parameter int N_BTN           = 3,
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [N_BTN-1:0] RawIn,
   output logic [N_BTN-1:0] Level,
   output logic [N_BTN-1:0] Press,
   output logic [N_BTN-1:0] Release
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk          (Clk),
         .rst          (Reset),
         .raw          (RawIn[i]),
         .level        (Level[i]),
         .press        (Press[i]),
         .release_pulse(Release[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner (N_BTN=3, DEBOUNCE_CYCLES=2).
// Expected {Level, Press, Release} for each edge is pushed to a queue as the
// stimulus for that edge is driven, then popped and compared #1 after the edge.
// Stimulus is written in terms of "pressed" masks so the same scenarios apply
// with or without BTN_ACTIVE_LOW_EN.
// ----------------------------------------------------------------------------
module tb_button_conditioner;
   import btn_pkg::*;

   localparam int N   = 3;
   localparam int DC  = 2;
   localparam int LAT = DC + 2;   // edges from first sampling edge to Level change

   localparam logic [N-1:0] ALL  = {N{1'b1}};
   localparam logic [N-1:0] NONE = {N{1'b0}};
`ifdef BTN_ACTIVE_LOW_EN
   localparam logic [N-1:0] IDLE = ALL;
`else
   localparam logic [N-1:0] IDLE = NONE;
`endif

   typedef struct packed {
      logic [N-1:0] level;
      logic [N-1:0] press;
      logic [N-1:0] rel;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Reset;
   logic [N-1:0] RawIn;
   logic [N-1:0] Level;
   logic [N-1:0] Press;
   logic [N-1:0] Release;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   button_conditioner #(
      .N_BTN          (N),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .RawIn  (RawIn),
      .Level  (Level),
      .Press  (Press),
      .Release(Release)
   );

   always #5 Clk = ~Clk;

   // Raw pin pattern for a given set of pressed buttons.
   function automatic logic [N-1:0] act(input logic [N-1:0] pressed);
      return IDLE ^ pressed;
   endfunction

   task automatic test_reset();
      exp_t e;
      Reset = 1'b1;
      RawIn = act(ALL);
      #1;
      exp_q.push_back(exp_t'{NONE, NONE, NONE});
      e = exp_q.pop_front();
      checks++;
      if ({Level, Press, Release} !== e) begin
         errors++;
         $display("FAIL reset_initial: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                  Level, Press, Release, e.level, e.press, e.rel);
      end
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(exp_t'{NONE, NONE, NONE});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL reset_hold edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      Reset = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         exp_q.push_back(exp_t'{(k >= LAT) ? ALL : NONE, (k == LAT) ? ALL : NONE, NONE});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL reset_held_press edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      RawIn = IDLE;
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back(exp_t'{(k < LAT) ? ALL : NONE, NONE, (k == LAT) ? ALL : NONE});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL reset_release_all edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
   endtask

   task automatic test_clean_press();
      exp_t         e;
      logic [N-1:0] m;
      m = NONE;
      m[BTN_LOADA] = 1'b1;
      for (int k = 1; k <= 2 * (LAT + 2); k++) begin
         if (k <= LAT + 2) begin
            RawIn = act(m);
            exp_q.push_back(exp_t'{(k >= LAT) ? m : NONE, (k == LAT) ? m : NONE, NONE});
         end else begin
            RawIn = IDLE;
            exp_q.push_back(exp_t'{(k - (LAT + 2) < LAT) ? m : NONE, NONE,
                                   (k - (LAT + 2) == LAT) ? m : NONE});
         end
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL clean_press edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
   endtask

   task automatic test_glitch();
      exp_t         e;
      logic [N-1:0] m;
      m = NONE;
      m[BTN_EXEC] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         RawIn = (k == 1) ? act(m) : IDLE;
         exp_q.push_back(exp_t'{NONE, NONE, NONE});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL glitch edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
   endtask

   task automatic test_bounce();
      localparam int RISE = 5 + LAT - 1;   // final 0->1 is sampled on edge 5
      exp_t         e;
      logic [N-1:0] m;
      logic [7:0]   seq;
      int           presses;
      m       = NONE;
      m[BTN_LOADB] = 1'b1;
      seq     = 8'b1111_0101;              // bit k-1 is the value for edge k
      presses = 0;
      for (int k = 1; k <= 10; k++) begin
         RawIn = (k > 8 || seq[k-1]) ? act(m) : IDLE;
         exp_q.push_back(exp_t'{(k >= RISE) ? m : NONE, (k == RISE) ? m : NONE, NONE});
         @(posedge Clk); #1;
         if (Press[BTN_LOADB]) presses++;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL bounce edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      checks++;
      if (presses !== 1) begin
         errors++;
         $display("FAIL bounce_press_count: got %0d want 1", presses);
      end
      RawIn = IDLE;
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back(exp_t'{(k < LAT) ? m : NONE, NONE, (k == LAT) ? m : NONE});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL bounce_release edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
   endtask

   // Simultaneous presses, then one channel released while another is pressed
   // on the same cycle, then everything released together.
   task automatic test_back_to_back();
      exp_t e;
      for (int k = 1; k <= 3 * (LAT + 1); k++) begin
         int ph;
         int j;
         ph = (k - 1) / (LAT + 1);
         j  = k - ph * (LAT + 1);
         if (ph == 0) begin
            RawIn = act(3'b101);
            exp_q.push_back(exp_t'{(j >= LAT) ? 3'b101 : 3'b000,
                                   (j == LAT) ? 3'b101 : 3'b000, 3'b000});
         end else if (ph == 1) begin
            RawIn = act(3'b110);
            exp_q.push_back(exp_t'{(j >= LAT) ? 3'b110 : 3'b101,
                                   (j == LAT) ? 3'b010 : 3'b000,
                                   (j == LAT) ? 3'b001 : 3'b000});
         end else begin
            RawIn = IDLE;
            exp_q.push_back(exp_t'{(j >= LAT) ? 3'b000 : 3'b110, 3'b000,
                                   (j == LAT) ? 3'b110 : 3'b000});
         end
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL back_to_back edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      exp_t e;
      // LoadB qualified and held so the asynchronous clear is visible on Level.
      RawIn = act(3'b010);
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back(exp_t'{(k >= LAT) ? 3'b010 : 3'b000,
                                (k == LAT) ? 3'b010 : 3'b000, 3'b000});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL midwait_setup edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      // LoadA pressed; after 3 edges channel 0 sits in WAIT_HI.
      RawIn = act(3'b011);
      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(exp_t'{3'b010, 3'b000, 3'b000});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL midwait_count edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      #2;
      Reset = 1'b1;
      exp_q.push_back(exp_t'{NONE, NONE, NONE});
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({Level, Press, Release} !== e) begin
         errors++;
         $display("FAIL midwait_async_clear: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                  Level, Press, Release, e.level, e.press, e.rel);
      end
      for (int k = 1; k <= 2; k++) begin
         exp_q.push_back(exp_t'{NONE, NONE, NONE});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL midwait_reset_hold edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      Reset = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back(exp_t'{(k >= LAT) ? 3'b011 : 3'b000,
                                (k == LAT) ? 3'b011 : 3'b000, 3'b000});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL midwait_requalify edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
      RawIn = IDLE;
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back(exp_t'{(k < LAT) ? 3'b011 : 3'b000, 3'b000,
                                (k == LAT) ? 3'b011 : 3'b000});
         @(posedge Clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({Level, Press, Release} !== e) begin
            errors++;
            $display("FAIL midwait_release edge %0d: got L=%b P=%b R=%b want L=%b P=%b R=%b",
                     k, Level, Press, Release, e.level, e.press, e.rel);
         end
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_back_to_back();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
